// File: rtl/turn_req_pkg.sv
// Shared types and constants for the left-turn request conditioner.
// Imported by the channel and the top; holds no logic.
package turn_req_pkg;

  localparam int TR_CNT_W  = 32;
  localparam int CH_MAIN   = 0;
  localparam int CH_SIDE   = 1;
  localparam int TR_NUM_CH = 2;

  typedef enum logic [1:0] {
    TR_IDLE    = 2'd0,
    TR_PENDING = 2'd1,
    TR_LOCKOUT = 2'd2
  } tr_state_e;

  typedef logic [TR_CNT_W-1:0] tr_cnt_t;

  localparam tr_cnt_t TR_CNT_ONE = tr_cnt_t'(1);

endpackage

// File: rtl/turn_req_channel.sv
// One turn-request channel: 2-flop sync, debounce, sticky request FSM with lockout; age timeout when TURN_REQ_TIMEOUT_EN is defined.
// Latency: req/press registered DEBOUNCE_CYCLES+2 edges after the first edge that samples btn high.
// Backpressure: none; ack is a one-cycle grant, press events outside IDLE are dropped.
module turn_req_channel
  import turn_req_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LOCKOUT_CYCLES  = 100_000_000,
  parameter tr_cnt_t     TIMEOUT_CYCLES  = 32'd3_000_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic ack,
  output logic req,
  output logic press,
  output logic expired
);

  localparam tr_cnt_t DEB_N  = tr_cnt_t'(DEBOUNCE_CYCLES);
  localparam tr_cnt_t LOCK_N = tr_cnt_t'(LOCKOUT_CYCLES);

  logic      sync1;
  logic      sync2;
  logic      deb;
  logic      deb_d;
  tr_cnt_t   deb_cnt;
  logic      press_evt;

  tr_state_e state_q;
  tr_state_e state_d;
  tr_cnt_t   lock_q;
  tr_cnt_t   lock_d;
  logic      press_q;
  logic      press_d;

  // btn is asynchronous to clk; nothing downstream looks at sync1.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      deb_d <= deb;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt + TR_CNT_ONE == DEB_N) begin
        deb     <= ~deb;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + TR_CNT_ONE;
      end
    end
  end

  // Only a rising debounced edge is a press; a held button yields one event.
  assign press_evt = deb & ~deb_d;

`ifdef TURN_REQ_TIMEOUT_EN
  tr_cnt_t age_q;
  tr_cnt_t age_d;
  logic    expired_q;
  logic    expired_d;
`else
  logic    unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    press_d = 1'b0;
`ifdef TURN_REQ_TIMEOUT_EN
    age_d     = '0;
    expired_d = 1'b0;
`endif
    unique case (state_q)
      TR_IDLE: begin
        if (press_evt) begin
          state_d = TR_PENDING;
          press_d = 1'b1;
        end
      end
      TR_PENDING: begin
        // Ack has priority over both a coincident press and the timeout.
        if (ack) begin
          lock_d = '0;
          if (LOCK_N == '0) begin
            state_d = TR_IDLE;
          end else begin
            state_d = TR_LOCKOUT;
          end
        end
`ifdef TURN_REQ_TIMEOUT_EN
        else if (age_q + TR_CNT_ONE == TIMEOUT_CYCLES) begin
          state_d   = TR_IDLE;
          expired_d = 1'b1;
        end else begin
          age_d = age_q + TR_CNT_ONE;
        end
`endif
      end
      TR_LOCKOUT: begin
        if (lock_q + TR_CNT_ONE == LOCK_N) begin
          state_d = TR_IDLE;
          lock_d  = '0;
        end else begin
          lock_d = lock_q + TR_CNT_ONE;
        end
      end
      default: begin
        state_d = TR_IDLE;
        lock_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TR_IDLE;
      lock_q  <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      press_q <= press_d;
    end
  end

`ifdef TURN_REQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      age_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      age_q     <= age_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;
`else
  assign expired = 1'b0;
`endif

  assign req   = (state_q == TR_PENDING);
  assign press = press_q;

endmodule

// File: rtl/turn_request_conditioner.sv
// Conditions main/side left-turn buttons into latched requests; two independent channels; timeout via TURN_REQ_TIMEOUT_EN.
// Latency: req/press DEBOUNCE_CYCLES+2 edges after the button is first sampled high; req drops on the ack edge.
// Backpressure: none; no arbitration here, the controller picks the service order and acks each channel.
module turn_request_conditioner
  import turn_req_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LOCKOUT_CYCLES  = 100_000_000,
  parameter tr_cnt_t     TIMEOUT_CYCLES  = 32'd3_000_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic main_btn,
  input  logic side_btn,
  input  logic main_ack,
  input  logic side_ack,
  output logic main_req,
  output logic side_req,
  output logic main_press,
  output logic side_press,
  output logic main_expired,
  output logic side_expired
);

  logic [TR_NUM_CH-1:0] btn;
  logic [TR_NUM_CH-1:0] ack;
  logic [TR_NUM_CH-1:0] req;
  logic [TR_NUM_CH-1:0] press;
  logic [TR_NUM_CH-1:0] expired;

  assign btn[CH_MAIN] = main_btn;
  assign btn[CH_SIDE] = side_btn;
  assign ack[CH_MAIN] = main_ack;
  assign ack[CH_SIDE] = side_ack;

  for (genvar ch = 0; ch < TR_NUM_CH; ch++) begin : g_ch
    turn_req_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LOCKOUT_CYCLES  (LOCKOUT_CYCLES),
      .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .btn     (btn[ch]),
      .ack     (ack[ch]),
      .req     (req[ch]),
      .press   (press[ch]),
      .expired (expired[ch])
    );
  end

  assign main_req     = req[CH_MAIN];
  assign side_req     = req[CH_SIDE];
  assign main_press   = press[CH_MAIN];
  assign side_press   = press[CH_SIDE];
  assign main_expired = expired[CH_MAIN];
  assign side_expired = expired[CH_SIDE];

endmodule

// File: tb/tb_turn_request_conditioner.sv
// Bench for turn_request_conditioner: directed scenarios plus random buttons/acks/resets against a window-based model.
module tb_turn_request_conditioner;

  localparam int D    = 4;
  localparam int L    = 8;
  localparam int T    = 10;
  localparam int HMAX = 64;
`ifdef TURN_REQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic main_btn = 1'b0;
  logic side_btn = 1'b0;
  logic main_ack = 1'b0;
  logic side_ack = 1'b0;
  logic main_req, side_req, main_press, side_press, main_expired, side_expired;

  always #5 clk = ~clk;

  turn_request_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .LOCKOUT_CYCLES  (L),
    .TIMEOUT_CYCLES  (32'd10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .main_btn     (main_btn),
    .side_btn     (side_btn),
    .main_ack     (main_ack),
    .side_ack     (side_ack),
    .main_req     (main_req),
    .side_req     (side_req),
    .main_press   (main_press),
    .side_press   (side_press),
    .main_expired (main_expired),
    .side_expired (side_expired)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model: raw-sample history per edge; the debounced level flips when the
  // last D synchronised samples since the last flip/reset all disagree with it.
  bit hist[2][HMAX];
  bit deb[2], pend[2], m_press[2], m_exp[2];
  int rst_edge[2], last_flip[2], rise_at[2], lock_end[2], pend_at[2];

  function automatic bit used_at(input int ch, input int m);
    if (m - 2 > rst_edge[ch]) return hist[ch][(m - 2) % HMAX];
    return 1'b0;
  endfunction

  task automatic model_step(input int ch, input bit b, input bit a);
    int n;
    bit all_diff;
    n = cyc;
    hist[ch][n % HMAX] = b;
    m_press[ch] = 1'b0;
    m_exp[ch]   = 1'b0;
    if (reset) begin
      rst_edge[ch]  = n;
      last_flip[ch] = n;
      deb[ch]       = 1'b0;
      rise_at[ch]   = -100;
      pend[ch]      = 1'b0;
      lock_end[ch]  = n;
    end else begin
      if (pend[ch]) begin
        if (a) begin
          pend[ch]     = 1'b0;
          lock_end[ch] = n + L;
        end else if (TO_EN && (n - pend_at[ch] == T)) begin
          pend[ch]     = 1'b0;
          m_exp[ch]    = 1'b1;
          lock_end[ch] = n;
        end
      end else if (rise_at[ch] == n - 1 && n > lock_end[ch]) begin
        pend[ch]    = 1'b1;
        pend_at[ch] = n;
        m_press[ch] = 1'b1;
      end
      all_diff = 1'b1;
      for (int k = 0; k < D; k++)
        if (n - k <= last_flip[ch] || used_at(ch, n - k) == deb[ch]) all_diff = 1'b0;
      if (all_diff) begin
        deb[ch]       = ~deb[ch];
        last_flip[ch] = n;
        if (deb[ch]) rise_at[ch] = n;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step(0, main_btn, main_ack);
      model_step(1, side_btn, side_ack);
      #1;
      check("main", {main_req, main_press, main_expired}, {pend[0], m_press[0], m_exp[0]});
      check("side", {side_req, side_press, side_expired}, {pend[1], m_press[1], m_exp[1]});
    end
  end

  task automatic drive(input bit mb, input bit sb, input bit ma, input bit sa);
    @(negedge clk);
    main_btn = mb;
    side_btn = sb;
    main_ack = ma;
    side_ack = sa;
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(negedge clk);
      main_ack = 1'b0;
      side_ack = 1'b0;
    end
  endtask

  // Edges from the first sampling edge to the press pulse; 99 if it never comes.
  task automatic wait_press(input int ch, input string tag);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if ((ch == 0) ? main_press : side_press) seen = 1'b1;
      else k++;
    end
    check(tag, seen ? k : 99, D + 2);
  endtask

  initial begin
    @(posedge clk);
    #1;
    check("reset", {main_req, side_req, main_press, side_press, main_expired, side_expired}, 6'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hold(3);

    // Clean press on main.
    drive(1, 0, 0, 0);
    wait_press(0, "clean_lat");
    check("side_quiet", {side_req, side_press}, 2'b00);

    // Release, then ack together with a re-press that lands inside the lockout.
    drive(0, 0, 0, 0);
    hold(8);
    drive(1, 0, 1, 0);
    @(posedge clk);
    #1;
    check("ack_drop", main_req, 1'b0);
    hold(12);
    check("lock_ign", main_req, 1'b0);
    drive(0, 0, 0, 0);
    hold(8);
    drive(1, 0, 0, 0);
    wait_press(0, "relock_lat");
    drive(1, 0, 1, 0);
    hold(12);
    drive(0, 0, 0, 0);
    hold(8);

    // Bounce: toggling every 2 cycles never settles long enough.
    for (int i = 0; i < 10; i++) begin
      drive(i % 2 == 0, 0, 0, 0);
      hold(1);
    end
    drive(0, 0, 0, 0);
    hold(10);
    check("bounce", main_req, 1'b0);
    drive(1, 0, 0, 0);
    wait_press(0, "bounce_lat");
    drive(1, 0, 1, 0);
    hold(12);
    drive(0, 0, 0, 0);
    hold(8);

    // Held side button through ack and lockout.
    drive(0, 1, 0, 0);
    wait_press(1, "side_lat");
    hold(3);
    drive(0, 1, 0, 1);
    hold(30);
    check("held_one", side_req, 1'b0);
    drive(0, 0, 0, 0);
    hold(8);
    drive(0, 1, 0, 0);
    wait_press(1, "held_new");
    drive(0, 1, 0, 1);
    drive(0, 0, 0, 0);
    hold(15);

    // Ack coincides with a press event while pending.
    drive(1, 0, 0, 0);
    wait_press(0, "sim_pre");
    drive(0, 0, 0, 0);
    hold(8);
    drive(1, 0, 0, 0);
    hold(5);
    drive(1, 0, 1, 0);
    @(posedge clk);
    #1;
    check("sim_ack", {main_req, main_press}, 2'b00);
    hold(12);
    drive(0, 0, 0, 0);
    hold(8);

    // Reset mid-pending with the button still held.
    drive(0, 1, 0, 0);
    wait_press(1, "rp_pre");
    hold(2);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid", {main_req, side_req, main_press, side_press, main_expired, side_expired}, 6'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_press(1, "rst_held");
    drive(0, 0, 0, 1);
    hold(12);

`ifdef TURN_REQ_TIMEOUT_EN
    begin
      int k;
      bit seen;
      drive(1, 0, 0, 0);
      wait_press(0, "to_pre");
      k = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk);
        #1;
        k++;
        if (main_expired) seen = 1'b1;
      end
      check("to_lat", seen ? k : 99, T);
      drive(0, 0, 0, 0);
      hold(8);
      drive(1, 0, 0, 0);
      wait_press(0, "to_pre2");
      repeat (9) @(negedge clk);
      drive(1, 0, 1, 0);
      @(posedge clk);
      #1;
      check("to_ack", {main_req, main_expired}, 2'b00);
      hold(12);
      drive(0, 0, 0, 0);
      hold(8);
    end
`endif

    // Random phase: slow-changing buttons, sparse acks, rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) main_btn = ~main_btn;
      if ($urandom_range(0, 11) == 0) side_btn = ~side_btn;
      main_ack = ($urandom_range(0, 9) == 0);
      side_ack = ($urandom_range(0, 9) == 0);
      reset    = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    reset    = 1'b0;
    main_ack = 1'b0;
    side_ack = 1'b0;
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/turn_request_conditioner.md
# turn_request_conditioner

Conditions the two raw left-turn push-buttons (main road, side road) into clean, latched turn requests for the traffic-light controller FSM. Each channel synchronises and debounces its button, turns a debounced press into a sticky request, holds it until the controller acknowledges service, then enforces a lockout window before accepting a new press. The block sits directly upstream of the traffic-light controller and feeds its left-turn request inputs.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles before the debounced level changes (10 ms at 100 MHz); must be ≥1.
- LOCKOUT_CYCLES, 100_000_000: cycles after an ack during which presses are ignored; 0 means no lockout.
- TIMEOUT_CYCLES, 32'd3_000_000_000: pending-request lifetime; used only with TURN_REQ_TIMEOUT_EN.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- main_btn  in  1  raw main-road left-turn button; asynchronous, bouncy.
- side_btn  in  1  raw side-road left-turn button; asynchronous, bouncy.
- main_ack  in  1  one-cycle pulse from the controller when the main left-turn phase is granted.
- side_ack  in  1  same, for the side road.
- main_req  out  1  main-road request pending (level).
- side_req  out  1  side-road request pending (level).
- main_press  out  1  one-cycle pulse when a main-road press is accepted.
- side_press  out  1  one-cycle pulse when a side-road press is accepted.
- main_expired  out  1  one-cycle pulse when a main-road request times out.
- side_expired  out  1  one-cycle pulse when a side-road request times out.

## Operation
- The two channels are identical and fully independent. No arbitration happens here; the controller decides the order of service.
- Synchroniser: 2 flops, reset to 0.
- Debouncer: the debounced level starts at 0 after reset. A 32-bit counter counts the cycles where the synchronised input differs from the debounced level. Any cycle where they match clears the counter. The debounced level flips when the counter reaches DEBOUNCE_CYCLES.
- A press event is a rising edge of the debounced level. Falling edges are ignored.
- Per-channel FSM:
  - IDLE (req=0): a press event moves to PENDING and pulses press.
  - PENDING (req=1): ack moves to LOCKOUT and loads the lockout counter. A press event here is absorbed, with no press pulse.
  - LOCKOUT (req=0): press events are ignored, with no pulse. The FSM returns to IDLE when the counter reaches LOCKOUT_CYCLES. With LOCKOUT_CYCLES=0, ack moves directly to IDLE.
- Ack in IDLE or LOCKOUT is ignored.
- A button held down produces exactly one request. A new request needs a release that is debounced low, then a new press.
- A button held through reset produces a press DEBOUNCE_CYCLES+2 cycles after reset deasserts.

## Timing
- Reset values: all outputs 0, FSMs in IDLE, all counters 0.
- Latency: if the first edge sampling btn=1 is E0, the debounced level rises at E(1+DEBOUNCE_CYCLES), and req and press are registered at E(2+DEBOUNCE_CYCLES).
- req falls on the edge that samples ack=1, so the controller sees req low on the next cycle.
- Ack and timeout in the same cycle: ack wins, and no expired pulse is issued.
- Ack and press event in the same PENDING cycle: ack wins, and the press is discarded.
- Reset asserted mid-debounce, mid-pending or mid-lockout returns the block to the reset state on the next edge. Pending requests are lost.

## Configuration
- TURN_REQ_TIMEOUT_EN defined:
  - PENDING runs a 32-bit age counter.
  - When the age counter reaches TIMEOUT_CYCLES, the FSM returns to IDLE (no lockout), req drops, and expired pulses for one cycle.
- TURN_REQ_TIMEOUT_EN undefined:
  - No age counter is built.
  - Requests stay pending until acked.
  - The expired outputs are tied to 0.

## Structure
- Shared package turn_req_pkg holds:
  - the channel-state enum: TR_IDLE=0, TR_PENDING=1, TR_LOCKOUT=2;
  - channel index constants: CH_MAIN=0, CH_SIDE=1;
  - the counter width constant TR_CNT_W=32.
- Sub-module turn_req_channel contains synchroniser, debouncer, FSM and counters for one channel. The top instantiates it twice.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and LOCKOUT_CYCLES=8 unless stated.
- Clean press: main_btn held high → main_press pulses and main_req rises exactly 6 cycles after the first sampling edge; side outputs stay 0.
- Bounce: main_btn toggled every 2 cycles for 20 cycles, then held low → no press, main_req stays 0. Then held high → a single press after 6 cycles.
- Ack and lockout: main_req=1, main_ack pulsed → main_req low the next cycle. A re-press inside 8 cycles is ignored. A re-press after the lockout sets main_req after 6 cycles.
- Held button: side_btn held high through an ack and the lockout → no second request until release plus a new press.
- Simultaneous events: ack in the same cycle as a press event → LOCKOUT, no press pulse. With TURN_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=10, ack on the timeout cycle → no expired pulse.
- Timeout (TURN_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=10): an unacked request → req drops and expired pulses after 10 cycles in PENDING. Reset asserted mid-PENDING → all outputs 0 on the next cycle.
